// File: rtl/gcd_pkg.sv
// Shared constants for the GCD host sequencer: state codes, default sizing
// and the state-to-busy decode.
package gcd_pkg;

    localparam int unsigned DEF_WIDTH       = 4;
    localparam int unsigned DEF_TIMEOUT_CYC = 64;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_GOT_X = 3'd1;
    localparam logic [2:0] ST_CHECK = 3'd2;
    localparam logic [2:0] ST_START = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;
    localparam logic [2:0] ST_HOLD  = 3'd5;

    // Bit n is the busy level for state code n; unused codes 6 and 7 read as idle.
    localparam logic [7:0] BUSY_MAP = 8'b0011_1110;

    function automatic logic state_busy(input logic [2:0] st);
        return BUSY_MAP[st];
    endfunction

endpackage

// File: rtl/gcd_host_seq_if.sv
// Host- and core-facing signal bundle of the GCD host sequencer.
// master = host/core side, slave = the sequencer itself.
interface gcd_host_seq_if
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) ();

    logic [WIDTH-1:0] data_i;
    logic             load_i;
    logic             ack_i;
    logic             done_i;
    logic [WIDTH-1:0] result_i;
    logic [WIDTH-1:0] x_o;
    logic [WIDTH-1:0] y_o;
    logic             start_o;
    logic [WIDTH-1:0] result_o;
    logic             valid_o;
    logic             busy_o;
    logic             err_o;

    modport master (
        output data_i, load_i, ack_i, done_i, result_i,
        input  x_o, y_o, start_o, result_o, valid_o, busy_o, err_o
    );

    modport slave (
        input  data_i, load_i, ack_i, done_i, result_i,
        output x_o, y_o, start_o, result_o, valid_o, busy_o, err_o
    );

endinterface

// File: rtl/gcd_host_wdog.sv
// WAIT-state watchdog for the GCD host sequencer; expired_o flags the
// LIMIT-th consecutive enabled cycle after a clear.
module gcd_host_wdog
    import gcd_pkg::*;
#(
    parameter  int unsigned LIMIT = DEF_TIMEOUT_CYC,
    localparam int unsigned CW    = $clog2(LIMIT + 1)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (en_i && !expired_o) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // The count holds cycles already spent, so the limit cycle sees LIMIT-1.
    assign expired_o = en_i && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/gcd_host_seq.sv
// Host-side sequencer: collects X/Y, starts the GCD core, returns the result
// over valid/ack. Define GCD_HOST_TIMEOUT_EN to add the WAIT-state watchdog.
module gcd_host_seq
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
`ifdef GCD_HOST_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
`endif
) (
    input logic           clk_i,
    input logic           rst_ni,
    gcd_host_seq_if.slave bus
);

    logic [2:0]       state_q;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] result_q;
    logic             timeout;
    logic             err_q;

`ifdef GCD_HOST_TIMEOUT_EN
    gcd_host_wdog #(
        .LIMIT (TIMEOUT_CYC)
    ) u_wdog (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (state_q == ST_START),
        .en_i      (state_q == ST_WAIT),
        .expired_o (timeout)
    );

    // A done pulse on the limit cycle wins, so err only sets without one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (state_q == ST_START) begin
            err_q <= 1'b0;
        end else if (state_q == ST_WAIT && !bus.done_i && timeout) begin
            err_q <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign err_q   = 1'b0;
`endif

    // NOTE: all state below is updated with <= so every branch sees the
    // pre-edge values of x_q/y_q, e.g. the zero test in CHECK.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.load_i) begin
                        x_q     <= bus.data_i;
                        state_q <= ST_GOT_X;
                    end
                end
                ST_GOT_X: begin
                    if (bus.load_i) begin
                        y_q     <= bus.data_i;
                        state_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    // A zero operand would hang the core; answer locally instead.
                    if (x_q == '0 || y_q == '0) begin
                        result_q <= x_q | y_q;
                        state_q  <= ST_HOLD;
                    end else begin
                        state_q  <= ST_START;
                    end
                end
                ST_START: state_q <= ST_WAIT;
                ST_WAIT: begin
                    if (bus.done_i) begin
                        result_q <= bus.result_i;
                        state_q  <= ST_HOLD;
                    end else if (timeout) begin
                        result_q <= '0;
                        state_q  <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (bus.ack_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.x_o      = x_q;
    assign bus.y_o      = y_q;
    assign bus.result_o = result_q;
    assign bus.start_o  = (state_q == ST_START);
    assign bus.valid_o  = (state_q == ST_HOLD);
    assign bus.busy_o   = state_busy(state_q);
    assign bus.err_o    = err_q;

endmodule

// File: doc/gcd_host_seq.md
Name: gcd_host_seq

Overview:
- Host-side sequencer for the subtractive GCD datapath/controller pair.
- Collects two operands from a narrow input bus and drives the start strobe into the GCD controller.
- Waits for the controller's output-enable/done pulse, then captures the result and presents it with a valid/ack handshake.
- Sits between the chip I/O pins and the GCD core; it is the initiator for the core's start/done interface.

Parameters:
- WIDTH, 4, operand and result width in bits.
- TIMEOUT_CYC, 64, watchdog limit in clock cycles; used only when the optional feature is compiled in.

Ports:
- clk_i  in  1  single system clock.
- rst_ni  in  1  asynchronous, active-low reset.
- data_i  in  WIDTH  operand bus, sampled when load_i=1.
- load_i  in  1  operand strobe; first strobe captures X, second captures Y.
- ack_i  in  1  host read acknowledge for the result.
- done_i  in  1  from GCD controller output-enable; one-cycle pulse.
- result_i  in  WIDTH  GCD datapath result; valid when done_i=1.
- x_o  out  WIDTH  operand X to the datapath.
- y_o  out  WIDTH  operand Y to the datapath.
- start_o  out  1  to the controller okey input; one-cycle pulse.
- result_o  out  WIDTH  captured GCD result.
- valid_o  out  1  result_o is valid.
- busy_o  out  1  high in any state other than IDLE.
- err_o  out  1  timeout flag; tied to 0 when the optional feature is absent.

Behaviour:
- Reset (async assert, sync deassert by the usual flop behaviour): state=IDLE; x_o, y_o, result_o = 0; start_o, valid_o, busy_o, err_o = 0.
- IDLE: load_i=1 -> capture data_i into x_o, go to GOT_X.
- GOT_X: load_i=1 -> capture data_i into y_o, go to CHECK.
- CHECK: one cycle, no stall.
  - If x_o==0 or y_o==0 -> result_o = x_o|y_o (so gcd(0,n)=n and gcd(0,0)=0), go to HOLD. start_o is never raised in this case, because a zero operand hangs the core.
  - Otherwise -> go to START.
- START: start_o=1 for exactly one cycle, go to WAIT.
- WAIT: x_o and y_o stay stable. done_i=1 -> result_o<=result_i, go to HOLD.
- HOLD: valid_o=1. ack_i=1 -> valid_o falls on the next edge, go to IDLE.
- Load rules:
  - load_i is ignored in CHECK, START, WAIT and HOLD; the operand registers are unchanged.
  - Simultaneous load_i and ack_i in HOLD: ack is accepted and the load is dropped.
- done_i outside WAIT is ignored.
- Latency:
  - Last load to start_o: 2 cycles.
  - done_i to valid_o: 1 cycle.
  - Zero-bypass, last load to valid_o: 2 cycles.
- Deasserting rst_ni in any state (including WAIT) aborts the transaction. The core is reset by its own reset; no start_o is re-issued.
- err_o is sticky until the next start_o or until reset.

Optional Feature:
- Macro: GCD_HOST_TIMEOUT_EN.
- Defined:
  - A cycle counter of width clog2(TIMEOUT_CYC+1) clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYC with no done_i: err_o<=1, result_o<=0, go to HOLD (valid_o=1 so the host can still drain).
  - done_i in the same cycle the limit is reached wins: normal capture, err_o stays 0.
- Undefined: no counter; err_o is constant 0; WAIT lasts indefinitely.

Decomposition:
- Shared package gcd_pkg holds:
  - state encoding (IDLE, GOT_X, CHECK, START, WAIT, HOLD) as 3-bit localparams;
  - default WIDTH and TIMEOUT_CYC;
  - state-to-busy mapping constant.
- One sub-module, gcd_host_wdog: the timeout counter with clear/enable/expired ports, instantiated only under GCD_HOST_TIMEOUT_EN.

Test Plan:
- Load 12 then 15 with WIDTH=4; model the core returning done_i with result_i=3 after 7 cycles -> start_o pulses exactly once, 2 cycles after the second load; valid_o=1 and result_o=3 one cycle after done_i; ack_i returns busy_o=0.
- Load 7 then 0 -> start_o never asserted; valid_o=1 with result_o=7, 2 cycles after the second load. Also load 0 and 0 -> result_o=0.
- Pulse load_i with data 9 during WAIT and during HOLD -> x_o and y_o unchanged; result unaffected.
- Drive rst_ni=0 mid-WAIT -> all outputs 0 immediately (async); after release, a fresh load of 8 and 4 completes with result 4.
- Under GCD_HOST_TIMEOUT_EN, TIMEOUT_CYC=16, done_i never arrives -> err_o=1, valid_o=1, result_o=0 at WAIT cycle 16. Repeat with done_i arriving on cycle 16 -> err_o=0 and the result is captured.
- Hold ack_i=1 continuously with back-to-back loads -> each result is presented for exactly one valid_o cycle; no start_o is lost or duplicated.
